// File: rtl/ds_pkg.sv
// ds_pkg - shared definitions for the block-averaging down-sampler.
//   state_t      : controller state encoding (IDLE, RD, DRAIN, WR, DONE)
//   clog2        : ceiling log2 usable in constant expressions
//   width_of     : counter width able to hold 0..count-1 (at least 1 bit)
//   round_term   : half-LSB constant added before the averaging shift
// Image-size derived constants (OUT_W, OUT_H, ACC_W) depend on module
// parameters and are therefore computed as localparams where they are used.
package ds_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RD    = 3'd1,
        ST_DRAIN = 3'd2,
        ST_WR    = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

    function automatic int width_of(input int count);
        int w;
        w = clog2(count);
        return (w < 1) ? 1 : w;
    endfunction

    // Sum of F*F samples is divided by 2**(2*log_f); rounding adds half of that.
    function automatic int round_term(input int log_f, input int round_en);
        if ((round_en != 0) && (log_f > 0)) begin
            return 1 << (2 * log_f - 1);
        end
        return 0;
    endfunction

endpackage

// File: rtl/downsample_engine_if.sv
// downsample_engine_if - host handshake plus single-port data-memory bus.
//   start/abort : host -> engine requests
//   busy/done   : engine -> host status
//   DM_addr, to_DM, DM_rd, DM_wr : engine -> memory
//   DM_data     : memory -> engine, valid the cycle after DM_rd
// modport master = engine side, modport slave = host/memory side.
interface downsample_engine_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 18
);
    logic              start;
    logic              abort;
    logic              busy;
    logic              done;
    logic [DATA_W-1:0] DM_data;
    logic [ADDR_W-1:0] DM_addr;
    logic [DATA_W-1:0] to_DM;
    logic              DM_rd;
    logic              DM_wr;

    modport master (
        input  start, abort, DM_data,
        output busy, done, DM_addr, to_DM, DM_rd, DM_wr
    );

    modport slave (
        output start, abort, DM_data,
        input  busy, done, DM_addr, to_DM, DM_rd, DM_wr
    );
endinterface

// File: rtl/ds_addr_gen.sv
// ds_addr_gen - block/tap counters and address generation.
//   clk, rst      : clock, asynchronous active-low reset
//   clear         : return all counters to zero
//   tap_adv       : step to the next tap inside the block (kx fastest, then ky)
//   pix_adv       : step to the next output pixel (ox fastest, then oy)
//   src_addr      : source address of the current tap (combinational)
//   dst_addr      : destination address of the current output pixel (combinational)
//   tap_home      : kx=ky=0 (tap counters have wrapped / not yet started)
//   pix_home      : ox=oy=0 (pixel counters have wrapped / not yet started)
// Both counter pairs wrap back to zero after their last value, so the
// controller recognises "block finished" and "image finished" by seeing the
// counters return home. All address arithmetic is modulo 2**ADDR_W.
module ds_addr_gen
    import ds_pkg::*;
#(
    parameter int ADDR_W   = 18,
    parameter int IMG_W    = 256,
    parameter int IMG_H    = 256,
    parameter int FACTOR   = 2,
    parameter int SRC_BASE = 0,
    parameter int DST_BASE = 65536
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              tap_adv,
    input  logic              pix_adv,
    output logic [ADDR_W-1:0] src_addr,
    output logic [ADDR_W-1:0] dst_addr,
    output logic              tap_home,
    output logic              pix_home
);
    localparam int OUT_W = IMG_W / FACTOR;
    localparam int OUT_H = IMG_H / FACTOR;
    localparam int KW    = width_of(FACTOR);
    localparam int XW    = width_of(OUT_W);
    localparam int YW    = width_of(OUT_H);

    logic [KW-1:0] kx_q, kx_d, ky_q, ky_d;
    logic [XW-1:0] ox_q, ox_d;
    logic [YW-1:0] oy_q, oy_d;

    logic kx_last, ky_last, ox_last, oy_last;
    logic [ADDR_W-1:0] row_a, col_a;

    assign kx_last = (kx_q == KW'(FACTOR - 1));
    assign ky_last = (ky_q == KW'(FACTOR - 1));
    assign ox_last = (ox_q == XW'(OUT_W - 1));
    assign oy_last = (oy_q == YW'(OUT_H - 1));

    assign tap_home = (kx_q == '0) && (ky_q == '0);
    assign pix_home = (ox_q == '0) && (oy_q == '0);

    always_comb begin
        kx_d = kx_q;
        ky_d = ky_q;
        ox_d = ox_q;
        oy_d = oy_q;
        if (clear) begin
            kx_d = '0;
            ky_d = '0;
            ox_d = '0;
            oy_d = '0;
        end else begin
            if (tap_adv) begin
                if (kx_last) begin
                    kx_d = '0;
                    ky_d = ky_last ? '0 : ky_q + 1'b1;
                end else begin
                    kx_d = kx_q + 1'b1;
                end
            end
            if (pix_adv) begin
                if (ox_last) begin
                    ox_d = '0;
                    oy_d = oy_last ? '0 : oy_q + 1'b1;
                end else begin
                    ox_d = ox_q + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            kx_q <= '0;
            ky_q <= '0;
            ox_q <= '0;
            oy_q <= '0;
        end else begin
            kx_q <= kx_d;
            ky_q <= ky_d;
            ox_q <= ox_d;
            oy_q <= oy_d;
        end
    end

    always_comb begin
        row_a    = ADDR_W'(oy_q) * ADDR_W'(FACTOR) + ADDR_W'(ky_q);
        col_a    = ADDR_W'(ox_q) * ADDR_W'(FACTOR) + ADDR_W'(kx_q);
        src_addr = ADDR_W'(SRC_BASE) + row_a * ADDR_W'(IMG_W) + col_a;
        dst_addr = ADDR_W'(DST_BASE) + ADDR_W'(oy_q) * ADDR_W'(OUT_W) + ADDR_W'(ox_q);
    end

endmodule

// File: rtl/downsample_engine.sv
// downsample_engine - averages FACTOR x FACTOR blocks of an IMG_W x IMG_H
// image in data memory and writes the reduced image back.
//   clk  : rising-edge clock
//   rst  : asynchronous active-low reset
//   bus  : downsample_engine_if.master (start/abort/busy/done + DM bus)
// Every output is registered. The address counters run one tap ahead of the
// bus: on the edge that issues a read they already advance, so during the
// last RD cycle they have wrapped home, which ends the read phase. The pixel
// counters advance on the DRAIN->WR edge, so a wrap seen in WR means the
// image is finished.
module downsample_engine
    import ds_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 18,
    parameter int IMG_W    = 256,
    parameter int IMG_H    = 256,
    parameter int FACTOR   = 2,
    parameter int SRC_BASE = 0,
    parameter int DST_BASE = 65536,
    parameter int ROUND    = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    downsample_engine_if.master  bus
);
    localparam int LOG_F = clog2(FACTOR);
    localparam int SHIFT = 2 * LOG_F;
    localparam int ACC_W = DATA_W + SHIFT;
    localparam int RND   = round_term(LOG_F, ROUND);

    generate
        if (!((FACTOR == 1) || (FACTOR == 2) || (FACTOR == 4) || (FACTOR == 8))) begin : g_bad_factor
            $error("downsample_engine: FACTOR must be 1, 2, 4 or 8");
        end
        if ((IMG_W % FACTOR) != 0) begin : g_bad_width
            $error("downsample_engine: IMG_W must be a multiple of FACTOR");
        end
        if ((IMG_H % FACTOR) != 0) begin : g_bad_height
            $error("downsample_engine: IMG_H must be a multiple of FACTOR");
        end
    endgenerate

    state_t state_q, state_d;

    logic [ACC_W-1:0]  acc_q, acc_d, acc_sum;
    logic [ADDR_W-1:0] dm_addr_q, dm_addr_d;
    logic [DATA_W-1:0] to_dm_q, to_dm_d;
    logic              dm_rd_q, dm_rd_d;
    logic              dm_wr_q, dm_wr_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              data_vld_q, data_vld_d;

    logic              tap_adv, pix_adv, cnt_clear;
    logic              tap_home, pix_home;
    logic [ADDR_W-1:0] src_addr, dst_addr;

    logic [ACC_W:0]    rounded, shifted;
    logic [DATA_W-1:0] pix_val;

    ds_addr_gen #(
        .ADDR_W   (ADDR_W),
        .IMG_W    (IMG_W),
        .IMG_H    (IMG_H),
        .FACTOR   (FACTOR),
        .SRC_BASE (SRC_BASE),
        .DST_BASE (DST_BASE)
    ) u_addr_gen (
        .clk      (clk),
        .rst      (rst),
        .clear    (cnt_clear),
        .tap_adv  (tap_adv),
        .pix_adv  (pix_adv),
        .src_addr (src_addr),
        .dst_addr (dst_addr),
        .tap_home (tap_home),
        .pix_home (pix_home)
    );

    // Read data arrives one cycle after its strobe; fold it in on that cycle.
    // The sum of F*F samples fits ACC_W bits, the rounding add needs one more.
    always_comb begin
        acc_sum = acc_q + (data_vld_q ? ACC_W'(bus.DM_data) : '0);
        rounded = {1'b0, acc_sum} + (ACC_W + 1)'(RND);
        shifted = rounded >> SHIFT;
        if (shifted > (ACC_W + 1)'({DATA_W{1'b1}})) begin
            pix_val = '1;
        end else begin
            pix_val = shifted[DATA_W-1:0];
        end
    end

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_sum;
        dm_addr_d = dm_addr_q;
        to_dm_d   = to_dm_q;
        dm_rd_d   = 1'b0;
        dm_wr_d   = 1'b0;
        tap_adv   = 1'b0;
        pix_adv   = 1'b0;
        cnt_clear = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    state_d   = ST_RD;
                    acc_d     = '0;
                    dm_rd_d   = 1'b1;
                    dm_addr_d = src_addr;
                    tap_adv   = 1'b1;
                end
            end
            ST_RD: begin
                if (tap_home) begin
                    state_d = ST_DRAIN;
                end else begin
                    dm_rd_d   = 1'b1;
                    dm_addr_d = src_addr;
                    tap_adv   = 1'b1;
                end
            end
            ST_DRAIN: begin
                // acc_sum already contains the final sample here.
                state_d   = ST_WR;
                dm_wr_d   = 1'b1;
                dm_addr_d = dst_addr;
                to_dm_d   = pix_val;
                pix_adv   = 1'b1;
            end
            ST_WR: begin
                acc_d = '0;
                if (pix_home) begin
                    state_d = ST_DONE;
                end else begin
                    state_d   = ST_RD;
                    dm_rd_d   = 1'b1;
                    dm_addr_d = src_addr;
                    tap_adv   = 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Abort cancels whatever was decided above, including a pending start.
        if (bus.abort) begin
            state_d   = ST_IDLE;
            acc_d     = '0;
            dm_addr_d = dm_addr_q;
            to_dm_d   = to_dm_q;
            dm_rd_d   = 1'b0;
            dm_wr_d   = 1'b0;
            tap_adv   = 1'b0;
            pix_adv   = 1'b0;
            cnt_clear = 1'b1;
        end

        busy_d     = (state_d != ST_IDLE);
        done_d     = (state_d == ST_DONE);
        data_vld_d = dm_rd_q && !bus.abort;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            acc_q      <= '0;
            dm_addr_q  <= '0;
            to_dm_q    <= '0;
            dm_rd_q    <= 1'b0;
            dm_wr_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            data_vld_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            dm_addr_q  <= dm_addr_d;
            to_dm_q    <= to_dm_d;
            dm_rd_q    <= dm_rd_d;
            dm_wr_q    <= dm_wr_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            data_vld_q <= data_vld_d;
        end
    end

    assign bus.DM_addr = dm_addr_q;
    assign bus.to_DM   = to_dm_q;
    assign bus.DM_rd   = dm_rd_q;
    assign bus.DM_wr   = dm_wr_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;

endmodule

// File: tb/tb_downsample_engine.sv
// tb_downsample_engine - directed bench for downsample_engine.
// Four engine instances with different geometry share one source memory
// model; sel chooses which instance is active and observed. Expected values
// are hand-computed block averages, addresses and cycle counts.
module tb_downsample_engine;

    logic clk;
    logic rst;
    logic start_v;
    logic abort_v;
    int   sel;

    int checks;
    int errors;

    logic [7:0]  src_mem [0:63];
    logic [7:0]  rdata_q;

    logic [17:0] obs_addr;
    logic [7:0]  obs_wdata;
    logic        obs_rd, obs_wr, obs_busy, obs_done;

    int   wr_addr [$];
    int   wr_data [$];
    int   wr_cyc  [$];
    logic overlap_seen;
    int   done_cyc;

    downsample_engine_if #(.DATA_W(8), .ADDR_W(18)) bus_a ();
    downsample_engine_if #(.DATA_W(8), .ADDR_W(18)) bus_b ();
    downsample_engine_if #(.DATA_W(8), .ADDR_W(18)) bus_c ();
    downsample_engine_if #(.DATA_W(8), .ADDR_W(18)) bus_d ();

    downsample_engine #(.IMG_W(4), .IMG_H(4), .FACTOR(2), .ROUND(1))
        dut_a (.clk(clk), .rst(rst), .bus(bus_a.master));
    downsample_engine #(.IMG_W(4), .IMG_H(4), .FACTOR(2), .ROUND(0))
        dut_b (.clk(clk), .rst(rst), .bus(bus_b.master));
    downsample_engine #(.IMG_W(8), .IMG_H(8), .FACTOR(4), .ROUND(1))
        dut_c (.clk(clk), .rst(rst), .bus(bus_c.master));
    downsample_engine #(.IMG_W(2), .IMG_H(2), .FACTOR(1), .ROUND(1))
        dut_d (.clk(clk), .rst(rst), .bus(bus_d.master));

    assign bus_a.start = start_v && (sel == 0);
    assign bus_b.start = start_v && (sel == 1);
    assign bus_c.start = start_v && (sel == 2);
    assign bus_d.start = start_v && (sel == 3);
    assign bus_a.abort = abort_v && (sel == 0);
    assign bus_b.abort = abort_v && (sel == 1);
    assign bus_c.abort = abort_v && (sel == 2);
    assign bus_d.abort = abort_v && (sel == 3);
    assign bus_a.DM_data = rdata_q;
    assign bus_b.DM_data = rdata_q;
    assign bus_c.DM_data = rdata_q;
    assign bus_d.DM_data = rdata_q;

    always_comb begin
        obs_addr  = '0;
        obs_wdata = '0;
        obs_rd    = 1'b0;
        obs_wr    = 1'b0;
        obs_busy  = 1'b0;
        obs_done  = 1'b0;
        case (sel)
            0: begin
                obs_addr = bus_a.DM_addr; obs_wdata = bus_a.to_DM; obs_rd = bus_a.DM_rd;
                obs_wr = bus_a.DM_wr; obs_busy = bus_a.busy; obs_done = bus_a.done;
            end
            1: begin
                obs_addr = bus_b.DM_addr; obs_wdata = bus_b.to_DM; obs_rd = bus_b.DM_rd;
                obs_wr = bus_b.DM_wr; obs_busy = bus_b.busy; obs_done = bus_b.done;
            end
            2: begin
                obs_addr = bus_c.DM_addr; obs_wdata = bus_c.to_DM; obs_rd = bus_c.DM_rd;
                obs_wr = bus_c.DM_wr; obs_busy = bus_c.busy; obs_done = bus_c.done;
            end
            3: begin
                obs_addr = bus_d.DM_addr; obs_wdata = bus_d.to_DM; obs_rd = bus_d.DM_rd;
                obs_wr = bus_d.DM_wr; obs_busy = bus_d.busy; obs_done = bus_d.done;
            end
            default: begin
                obs_addr = '0;
            end
        endcase
    end

    // Registered-read source memory: data follows the strobe by one cycle.
    always @(posedge clk) begin
        if (obs_rd) begin
            rdata_q <= src_mem[obs_addr[5:0]];
        end
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Pulse start, then watch the active instance cycle by cycle. cyc=1 is the
    // first cycle after the edge that sampled start.
    task automatic run(input int budget, input int restart_at, input int abort_at);
        int cyc;
        wr_addr.delete();
        wr_data.delete();
        wr_cyc.delete();
        overlap_seen = 1'b0;
        done_cyc     = -1;
        @(negedge clk);
        start_v = 1'b1;
        @(posedge clk);
        #1;
        start_v = 1'b0;
        cyc = 1;
        chk("busy_after_start", {31'd0, obs_busy}, 32'd1);
        while (cyc <= budget) begin
            if (obs_wr) begin
                wr_addr.push_back(int'(obs_addr));
                wr_data.push_back(int'(obs_wdata));
                wr_cyc.push_back(cyc);
            end
            if (obs_wr && obs_done) overlap_seen = 1'b1;
            if (obs_done && (done_cyc < 0)) done_cyc = cyc;
            if (cyc == abort_at + 1) begin
                chk("busy_after_abort", {31'd0, obs_busy}, 32'd0);
                chk("rd_after_abort", {31'd0, obs_rd}, 32'd0);
            end
            if ((done_cyc >= 0) && (cyc == done_cyc + 1)) begin
                chk("busy_after_done", {31'd0, obs_busy}, 32'd0);
                break;
            end
            abort_v = (cyc == abort_at);
            start_v = (cyc == restart_at);
            @(posedge clk);
            #1;
            cyc++;
        end
        start_v = 1'b0;
        abort_v = 1'b0;
        chk("wr_done_overlap", {31'd0, overlap_seen}, 32'd0);
        repeat (2) @(posedge clk);
    endtask

    task automatic check_writes(input string tag, input int d0, input int d1, input int d2, input int d3);
        int exp_d [4];
        exp_d = '{d0, d1, d2, d3};
        chk($sformatf("%s_wr_count", tag), wr_data.size(), 4);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("%s_addr%0d", tag, k), wr_addr[k], 65536 + k);
            chk($sformatf("%s_data%0d", tag, k), wr_data[k], exp_d[k]);
        end
    endtask

    task automatic fill(input int value);
        for (int i = 0; i < 64; i++) src_mem[i] = value[7:0];
    endtask

    initial begin
        rst     = 1'b0;
        start_v = 1'b0;
        abort_v = 1'b0;
        sel     = 0;
        checks  = 0;
        errors  = 0;
        fill(0);

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        chk("rst_addr", {14'd0, obs_addr}, 32'd0);
        chk("rst_wdata", {24'd0, obs_wdata}, 32'd0);
        chk("rst_rd", {31'd0, obs_rd}, 32'd0);
        chk("rst_wr", {31'd0, obs_wr}, 32'd0);
        chk("rst_busy", {31'd0, obs_busy}, 32'd0);
        chk("rst_done", {31'd0, obs_done}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(posedge clk);

        // 4x4 F=2, flat 100: four writes of 100, done at 4*6+1
        sel = 0;
        fill(100);
        run(40, -1, -1);
        $display("t1 flat100 done_cyc=%0d writes=%0d", done_cyc, wr_data.size());
        chk("t1_done_cycle", done_cyc, 25);
        check_writes("t1", 100, 100, 100, 100);
        chk("t1_wr_spacing", wr_cyc[1] - wr_cyc[0], 6);

        // Block0 {1,2,3,4} sum 10 -> 2.5; block1 all 255; rest 0
        fill(0);
        src_mem[0] = 8'd1; src_mem[1] = 8'd2; src_mem[4] = 8'd3; src_mem[5] = 8'd4;
        src_mem[2] = 8'd255; src_mem[3] = 8'd255; src_mem[6] = 8'd255; src_mem[7] = 8'd255;
        run(40, -1, -1);
        $display("t2 round done_cyc=%0d writes=%0d", done_cyc, wr_data.size());
        check_writes("t2_round", 3, 255, 0, 0);
        sel = 1;
        run(40, -1, -1);
        $display("t2 trunc done_cyc=%0d writes=%0d", done_cyc, wr_data.size());
        check_writes("t2_trunc", 2, 255, 0, 0);
        chk("t2_trunc_done_cycle", done_cyc, 25);

        // 8x8 F=4, ramp x+8y: block sums 216,280,728,792 /16 -> 13.5,17.5,45.5,49.5
        sel = 2;
        for (int i = 0; i < 64; i++) src_mem[i] = 8'(i);
        run(100, -1, -1);
        $display("t3 ramp done_cyc=%0d writes=%0d", done_cyc, wr_data.size());
        check_writes("t3", 14, 18, 46, 50);
        chk("t3_wr_spacing", wr_cyc[1] - wr_cyc[0], 18);
        chk("t3_done_cycle", done_cyc, 73);

        // F=1 copy of 2x2 {7,8,9,10}
        sel = 3;
        fill(0);
        src_mem[0] = 8'd7; src_mem[1] = 8'd8; src_mem[2] = 8'd9; src_mem[3] = 8'd10;
        run(30, -1, -1);
        $display("t4 copy done_cyc=%0d writes=%0d", done_cyc, wr_data.size());
        check_writes("t4", 7, 8, 9, 10);
        chk("t4_wr_spacing", wr_cyc[3] - wr_cyc[2], 3);
        chk("t4_done_cycle", done_cyc, 13);

        // Second start mid-run is ignored
        sel = 0;
        fill(100);
        run(40, 8, -1);
        $display("t5 restart done_cyc=%0d writes=%0d", done_cyc, wr_data.size());
        check_writes("t5", 100, 100, 100, 100);
        chk("t5_done_cycle", done_cyc, 25);

        // Abort in cycle 8 (second pixel's RD): one write, no done
        run(40, -1, 8);
        $display("t6 abort done_cyc=%0d writes=%0d", done_cyc, wr_data.size());
        chk("t6_wr_count", wr_data.size(), 1);
        chk("t6_no_done", done_cyc, -1);
        run(40, -1, -1);
        $display("t6 rerun done_cyc=%0d writes=%0d", done_cyc, wr_data.size());
        check_writes("t6_rerun", 100, 100, 100, 100);
        chk("t6_rerun_done_cycle", done_cyc, 25);

        // Reset asserted during the first WR cycle (cycle 6)
        @(negedge clk);
        start_v = 1'b1;
        @(posedge clk);
        #1;
        start_v = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("t7_wr_before_rst", {31'd0, obs_wr}, 32'd1);
        rst = 1'b0;
        #1;
        $display("t7 rst in WR wr=%0d busy=%0d addr=%0d", obs_wr, obs_busy, obs_addr);
        chk("t7_rst_wr", {31'd0, obs_wr}, 32'd0);
        chk("t7_rst_busy", {31'd0, obs_busy}, 32'd0);
        chk("t7_rst_rd", {31'd0, obs_rd}, 32'd0);
        chk("t7_rst_done", {31'd0, obs_done}, 32'd0);
        chk("t7_rst_addr", {14'd0, obs_addr}, 32'd0);
        chk("t7_rst_wdata", {24'd0, obs_wdata}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("t7_idle_after_rst", {30'd0, obs_busy, obs_wr}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
